// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline: operand forwarding, load-use
// stalls, branch flushes and the data-memory wait sequencer with debug counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic [4:0]           rs1_e,
    input  logic [4:0]           rs2_e,
    input  logic [4:0]           rd_e,
    input  logic                 res_src_e0,
    input  logic                 pc_src_e,
    input  logic [4:0]           rd_m,
    input  logic                 reg_write_m,
    input  logic                 mem_access_m,
    input  logic                 mem_ready,
    input  logic [4:0]           rd_w,
    input  logic                 reg_write_w,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 stall_w,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);

    localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } mem_state_t;

    mem_state_t           state_reg;
    logic [WCNT_W-1:0]    wait_cnt_reg;
    logic                 mem_err_reg;
    logic [CNT_WIDTH-1:0] stall_cnt_reg;
    logic [CNT_WIDTH-1:0] flush_cnt_reg;

    logic                 mem_stall;
    logic                 lw_raw;
    logic                 lw_stall;
    logic [1:0][4:0]      rs_e;
    logic [1:0][1:0]      fwd_sel;

    // The stall drops in the cycle the access completes or times out, so the
    // M-stage instruction leaves and cannot retrigger a new wait.
    always_comb begin
        mem_stall = 1'b0;
        if (state_reg == S_IDLE) begin
            mem_stall = mem_access_m & ~mem_ready;
        end else begin
            mem_stall = ~mem_ready & (wait_cnt_reg != TIMEOUT_VAL);
        end
    end

    assign rs_e = {rs2_e, rs1_e};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e[gi])) begin
                    fwd_sel[gi] = 2'b10;
                end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e[gi])) begin
                    fwd_sel[gi] = 2'b01;
                end
            end
        end
    endgenerate

    assign lw_raw   = res_src_e0 & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    // A taken branch squashes the dependent decode instruction, so no stall is needed.
    assign lw_stall = lw_raw & ~pc_src_e & ~mem_stall & ~rst;

    assign forward_a_e  = rst ? 2'b00 : fwd_sel[0];
    assign forward_b_e  = rst ? 2'b00 : fwd_sel[1];
    assign stall_f      = ~rst & (mem_stall | lw_stall);
    assign stall_d      = ~rst & (mem_stall | lw_stall);
    assign stall_e      = ~rst & mem_stall;
    assign stall_m      = ~rst & mem_stall;
    assign stall_w      = ~rst & mem_stall;
    assign flush_d      = ~rst & ~mem_stall & pc_src_e;
    assign flush_e      = ~rst & ~mem_stall & (pc_src_e | lw_stall);
    assign mem_err      = mem_err_reg;
    assign stall_cycles = stall_cnt_reg;
    assign flush_events = flush_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (mem_access_m && !mem_ready) begin
                        state_reg    <= S_WAIT;
                        wait_cnt_reg <= WCNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        state_reg    <= S_IDLE;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == TIMEOUT_VAL) begin
                        state_reg    <= S_IDLE;
                        wait_cnt_reg <= '0;
                        mem_err_reg  <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WCNT_W'(1);
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_f) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
            end
            if (flush_d) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

endmodule
